inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port redirect_i  input  1  taken jump/branch from decode; flush and refetch.
REQ-006 SHALL have port redirect_pc_i  input  XLEN  redirect target.
REQ-007 SHALL have port imem_req_o  output  1  instruction memory request valid.
REQ-008 SHALL have port imem_addr_o  output  XLEN  request word address.
REQ-009 SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-010 SHALL have port imem_rvalid_i  input  1  response valid; responses in request order, at least 1 cycle after grant.
REQ-011 SHALL have port imem_rdata_i  input  32  response instruction word.
REQ-012 SHALL have port inst_valid_o  output  1  instruction available to decode.
REQ-013 SHALL have port inst_data_o  output  32  instruction word to decode.
REQ-014 SHALL have port inst_pc_o  output  XLEN  PC of inst_data_o.
REQ-015 SHALL have port inst_ready_i  input  1  decode consumes; transfer when inst_valid_o & inst_ready_i.

Function
REQ-016 SHALL implement FSM states RUN and HALT; reset enters RUN.
REQ-017 SHALL hold fetch_pc; each granted request advances it by 4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 0).
REQ-018 SHALL buffer responses in a 2-entry in-order FIFO holding {pc, word}; head drives inst_data_o/inst_pc_o.
REQ-019 SHALL assert imem_req_o only in RUN, when no redirect_i is present, and when outstanding + buffered - pop < 2.
REQ-020 SHALL keep imem_req_o and imem_addr_o stable while imem_req_o=1 and imem_gnt_i=0.
REQ-021 SHALL provide one instruction per cycle sustained with 1-cycle memory: first inst_valid_o two cycles after the first grant.
REQ-022 SHALL handle redirect_i as follows: flush the FIFO, set fetch_pc to redirect_pc_i, and discard all outstanding responses, counted by a 2-bit drop counter.
REQ-023 SHALL treat redirect_i with a simultaneous pop as follows: redirect wins, the pop is void and the FIFO empties.
REQ-024 SHALL discard an imem_rvalid_i arriving in the same cycle as redirect_i.
REQ-025 SHALL add a request granted in the same cycle as redirect_i to the drop count.
REQ-026 SHALL issue the first request to redirect_pc_i in the cycle after redirect_i.
REQ-027 SHALL never drop a non-discarded response; imem_rvalid_i with a full FIFO is impossible by REQ-019.
REQ-028 SHALL keep inst_valid_o low while the FIFO is empty; there is no combinational bypass from imem_rdata_i.

Reset
REQ-029 SHALL, while rst_i=1, clear imem_req_o, inst_valid_o, FIFO, outstanding and drop counters, set fetch_pc=RESET_PC, and drive inst_data_o=0, inst_pc_o=0, imem_addr_o=RESET_PC.
REQ-030 SHALL, on reset asserted mid-operation, abandon in-flight responses; memory is reset together with this block.

Configuration
REQ-031 SHALL support macro INST_FETCH_MISALIGN_EN.
REQ-032 SHALL, with INST_FETCH_MISALIGN_EN defined, add port misalign_o (output, 1, sticky) and handle redirect_pc_i[1:0]!=0 with redirect_i by: enter HALT, flush, stop requesting, assert misalign_o until reset.
REQ-033 SHALL, without INST_FETCH_MISALIGN_EN, not exist port misalign_o, never enter HALT, and use redirect_pc_i with bits [1:0] forced to 0.

Structure
REQ-034 SHALL place the fetch FSM state enum and the default RESET_PC constant in shared package fetch_pkg.
REQ-035 SHALL implement the 2-entry FIFO as sub-module fetch_buf, parameterised by entry width.

Verification
REQ-036 SHALL verify: reset release, 1-cycle memory, inst_ready_i=1 -> addresses 0x0,0x4,0x8 granted on consecutive cycles; inst_valid_o first high 2 cycles after first grant, then every cycle.
REQ-037 SHALL verify: inst_ready_i=0 for 5 cycles -> at most 2 requests issued; FIFO holds PCs 0x0,0x4; no further imem_req_o.
REQ-038 SHALL verify: redirect_i to 0x100 with 2 responses outstanding -> both responses discarded; next inst_pc_o=0x100.
REQ-039 SHALL verify: redirect_i to 0x40 with simultaneous pop and imem_rvalid_i -> FIFO empty next cycle; first request addr 0x40 next cycle.
REQ-040 SHALL verify: fetch from 0xFFFF_FFFC -> next request addr 0x0.
REQ-041 SHALL verify, with INST_FETCH_MISALIGN_EN: redirect to 0x102 -> misalign_o=1, imem_req_o=0 held until rst_i.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order FIFO between instruction memory and decode.
module fetch_buf #(
    parameter int unsigned W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_q;
    logic         wr_q;
    logic [1:0]   cnt_q;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, imem requests, response buffering.
// Optional INST_FETCH_MISALIGN_EN halts on misaligned redirect targets.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_data_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
`ifdef INST_FETCH_MISALIGN_EN
    ,
    output logic            misalign_o
`endif
);

    localparam int unsigned EW = XLEN + 32;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [1:0]      outst_q, outst_d;
    logic [1:0]      drop_q, drop_d;
    logic [XLEN-1:0] target;
    logic            bad_target;
    logic            pop;
    logic            granted;
    logic [2:0]      live;
    logic [2:0]      inflight;
    logic [2:0]      lost;
    logic            buf_push;
    logic            buf_valid;
    logic [1:0]      buf_count;
    logic [EW-1:0]   buf_head;

`ifdef INST_FETCH_MISALIGN_EN
    logic misalign_q, misalign_d;
    assign target     = redirect_pc_i;
    assign bad_target = |redirect_pc_i[1:0];
    assign misalign_o = misalign_q;
`else
    assign target     = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign bad_target = 1'b0;
`endif

    assign pop      = buf_valid && inst_ready_i && !redirect_i;
    assign live     = {1'b0, outst_q} + {1'b0, buf_count} - {2'b00, pop};
    assign inflight = {1'b0, outst_q} + {1'b0, drop_q};
    // Doomed responses still occupy the 2-bit drop counter, so total is capped at 3.
    assign imem_req_o = !rst_i && (state_q == RUN) && !redirect_i
                        && (live < 3'd2) && (inflight < 3'd3);
    assign granted     = imem_req_o && imem_gnt_i;
    assign imem_addr_o = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        buf_push   = 1'b0;
        lost       = {1'b0, drop_q} + {1'b0, outst_q}
                     + {2'b00, imem_gnt_i} - {2'b00, imem_rvalid_i};
`ifdef INST_FETCH_MISALIGN_EN
        misalign_d = misalign_q;
`endif
        if (redirect_i) begin
            // Everything still in flight, including a racing grant, is discarded.
            drop_d     = (lost > 3'd3) ? 2'd3 : lost[1:0];
            outst_d    = 2'd0;
            fetch_pc_d = target;
            resp_pc_d  = target;
            if (bad_target) begin
                state_d = HALT;
`ifdef INST_FETCH_MISALIGN_EN
                misalign_d = 1'b1;
`endif
            end
        end else begin
            if (imem_rvalid_i) begin
                if (drop_q != 2'd0) begin
                    drop_d = drop_q - 2'd1;
                end else begin
                    buf_push  = 1'b1;
                    resp_pc_d = resp_pc_q + XLEN'(4);
                    outst_d   = outst_q - 2'd1;
                end
            end
            if (granted) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                outst_d    = outst_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= 2'd0;
            drop_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

`ifdef INST_FETCH_MISALIGN_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    fetch_buf #(
        .W(EW)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (buf_push),
        .data_i  ({resp_pc_q, imem_rdata_i}),
        .pop_i   (pop),
        .valid_o (buf_valid),
        .data_o  (buf_head),
        .count_o (buf_count)
    );

    assign inst_valid_o = buf_valid;
    assign inst_pc_o    = buf_head[EW-1:32];
    assign inst_data_o  = buf_head[31:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small in-order imem model.
module tb_inst_fetch;

    localparam logic [31:0] K = 32'h1300_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect, req, gnt, rvalid, ivalid, ready;
    logic [31:0] redirect_pc, addr, rdata, idata, ipc;
    logic        gnt_en, resp_en;
`ifdef INST_FETCH_MISALIGN_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;
    int gcount   = 0;
    int g0;
    logic ok;

    inst_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .inst_valid_o  (ivalid),
        .inst_data_o   (idata),
        .inst_pc_o     (ipc),
        .inst_ready_i  (ready)
`ifdef INST_FETCH_MISALIGN_EN
        ,
        .misalign_o    (misalign)
`endif
    );

    // In-order memory: grants immediately, answers one cycle later when enabled.
    logic [31:0] pend_q [4];
    logic [1:0]  hd_q, tl_q, hd_n;
    logic [2:0]  cnt_q, cnt_n;
    logic        m_push, m_pop;
    logic [31:0] head_n;

    assign gnt = req & gnt_en;

    always_comb begin
        m_push = req & gnt;
        m_pop  = rvalid;
        cnt_n  = cnt_q + {2'b00, m_push} - {2'b00, m_pop};
        hd_n   = hd_q + {1'b0, m_pop};
        head_n = ((cnt_q - {2'b00, m_pop}) == 3'd0) ? addr : pend_q[hd_n];
    end

    always @(posedge clk) begin
        if (rst) begin
            hd_q   <= 2'd0;
            tl_q   <= 2'd0;
            cnt_q  <= 3'd0;
            rvalid <= 1'b0;
            rdata  <= 32'd0;
        end else begin
            if (m_push) begin
                pend_q[tl_q] <= addr;
                tl_q         <= tl_q + 2'd1;
            end
            hd_q   <= hd_n;
            cnt_q  <= cnt_n;
            rvalid <= resp_en && (cnt_n != 3'd0);
            rdata  <= head_n ^ K;
        end
    end

    always @(posedge clk) begin
        if (req && gnt) gcount <= gcount + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output logic seen);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ivalid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        ready       = 1'b1;
        gnt_en      = 1'b1;
        resp_en     = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state and streaming
        reset_dut();
        check("rst_req", 64'(req), 64'd0);
        check("rst_valid", 64'(ivalid), 64'd0);
        check("rst_data", 64'(idata), 64'd0);
        check("rst_pc", 64'(ipc), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        rst = 1'b0;
        #1;
        check("s_req0", 64'(req), 64'd1);
        check("s_addr0", 64'(addr), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("s_req", 64'(req), 64'd1);
            check("s_addr", 64'(addr), 64'(k * 4));
            if (k < 2) begin
                check("s_novalid", 64'(ivalid), 64'd0);
            end else begin
                check("s_valid", 64'(ivalid), 64'd1);
                check("s_pc", 64'(ipc), 64'((k - 2) * 4));
                check("s_data", 64'(idata), 64'(32'((k - 2) * 4) ^ K));
            end
        end

        // Decode stalled: only two requests, FIFO holds 0x0,0x4
        reset_dut();
        ready = 1'b0;
        g0    = gcount;
        rst   = 1'b0;
        repeat (6) @(negedge clk);
        check("stall_grants", 64'(gcount - g0), 64'd2);
        check("stall_req", 64'(req), 64'd0);
        check("stall_valid", 64'(ivalid), 64'd1);
        check("stall_pc0", 64'(ipc), 64'h0);
        ready = 1'b1;
        #1;
        check("stall_req_pop", 64'(req), 64'd1);
        check("stall_addr8", 64'(addr), 64'h8);
        @(negedge clk);
        check("stall_pc4", 64'(ipc), 64'h4);

        // Redirect with two responses outstanding
        reset_dut();
        resp_en = 1'b0;
        g0      = gcount;
        rst     = 1'b0;
        repeat (4) @(negedge clk);
        check("rd_grants", 64'(gcount - g0), 64'd2);
        check("rd_capped", 64'(req), 64'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        resp_en     = 1'b1;
        #1;
        check("rd_req_off", 64'(req), 64'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("rd_req_on", 64'(req), 64'd1);
        check("rd_addr", 64'(addr), 64'h100);
        wait_valid(ok);
        check("rd_seen", 64'(ok), 64'd1);
        check("rd_pc", 64'(ipc), 64'h100);
        check("rd_data", 64'(idata), 64'(32'h100 ^ K));

        // Redirect racing a pop and a response
        reset_dut();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rp_pre_valid", 64'(ivalid), 64'd1);
        check("rp_pre_pc", 64'(ipc), 64'h4);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("rp_req_off", 64'(req), 64'd0);
        @(negedge clk);
        redirect = 1'b0;
        check("rp_empty", 64'(ivalid), 64'd0);
        #1;
        check("rp_req_on", 64'(req), 64'd1);
        check("rp_addr", 64'(addr), 64'h40);
        wait_valid(ok);
        check("rp_seen", 64'(ok), 64'd1);
        check("rp_pc", 64'(ipc), 64'h40);
        @(negedge clk);
        check("rp_pc_next", 64'(ipc), 64'h44);

        // Address wrap
        reset_dut();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        rst         = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("wr_req", 64'(req), 64'd1);
        check("wr_addr_top", 64'(addr), 64'hFFFF_FFFC);
        @(negedge clk);
        check("wr_addr_zero", 64'(addr), 64'h0);
        wait_valid(ok);
        check("wr_seen", 64'(ok), 64'd1);
        check("wr_pc_top", 64'(ipc), 64'hFFFF_FFFC);
        @(negedge clk);
        check("wr_valid", 64'(ivalid), 64'd1);
        check("wr_pc_zero", 64'(ipc), 64'h0);

        // Misaligned redirect target
        reset_dut();
        rst = 1'b0;
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
`ifdef INST_FETCH_MISALIGN_EN
        #1;
        check("ma_flag", 64'(misalign), 64'd1);
        check("ma_req", 64'(req), 64'd0);
        repeat (5) @(negedge clk);
        check("ma_req_held", 64'(req), 64'd0);
        check("ma_flag_held", 64'(misalign), 64'd1);
        check("ma_novalid", 64'(ivalid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ma_flag_rst", 64'(misalign), 64'd0);
        rst = 1'b0;
        #1;
        check("ma_req_rst", 64'(req), 64'd1);
`else
        #1;
        check("ma_req", 64'(req), 64'd1);
        check("ma_addr", 64'(addr), 64'h100);
        wait_valid(ok);
        check("ma_seen", 64'(ok), 64'd1);
        check("ma_pc", 64'(ipc), 64'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
